// File: rtl/decode_pkg.sv
// Shared constants and the ID/EX control bundle for the MIPS decode stage.
package decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctrl_e;

  typedef struct packed {
    logic      reg_write;
    logic      memto_reg;
    logic      mem_write;
    logic      alu_src;
    logic      reg_dst;
    alu_ctrl_e alu_ctrl;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } idex_ctrl_t;

endpackage

// File: rtl/reg_file_bypass.sv
// Register file with r0 hardwired to zero, out-of-range reads returning zero,
// and write-through bypass from the writeback port.
module reg_file_bypass #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  we,
  input  logic [4:0]            wa,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic [4:0]            ra1,
  input  logic [4:0]            ra2,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2
);

  localparam logic [5:0] NREGS = 6'(NUM_REGS);

  logic [DATA_WIDTH-1:0] mem [NUM_REGS];
  logic                  write_ok;

  function automatic logic in_range(input logic [4:0] a);
    return (a != 5'd0) && ({1'b0, a} < NREGS);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] lookup(input logic [4:0] a);
    logic [DATA_WIDTH-1:0] v;
    v = '0;
    if (in_range(a)) begin
      if (we && (a == wa)) begin
        v = wd;
      end else begin
        for (int i = 1; i < NUM_REGS; i++) begin
          if (a == 5'(i)) v = mem[i];
        end
      end
    end
    return v;
  endfunction

  assign write_ok = we && in_range(wa);

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (write_ok) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (wa == 5'(i)) mem[i] <= wd;
      end
    end
  end

  always_comb begin
    rd1 = lookup(ra1);
    rd2 = lookup(ra2);
  end

endmodule

// File: rtl/decode_stage_pipelined.sv
// MIPS decode stage: decoder, bypassed register file, branch resolution with
// M-stage forwarding, load-use/branch hazard detection and the ID/EX register.
module decode_stage_pipelined
  import decode_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter bit BNE_EN     = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [31:0]           InstrD,
  input  logic [31:0]           PCPlus4D,
  input  logic                  ValidD,
  input  logic                  RegWriteW,
  input  logic [4:0]            WriteRegW,
  input  logic [DATA_WIDTH-1:0] ResultW,
  input  logic                  RegWriteM,
  input  logic                  MemtoRegM,
  input  logic [4:0]            WriteRegM,
  input  logic [DATA_WIDTH-1:0] ALUOutM,
  output logic [1:0]            PCSrcD,
  output logic [31:0]           PCBranchD,
  output logic [31:0]           PCJumpD,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  FlushD,
  output logic                  ValidE,
  output logic                  RegWriteE,
  output logic                  MemtoRegE,
  output logic                  MemWriteE,
  output logic                  ALUSrcE,
  output logic                  RegDstE,
  output logic [2:0]            ALUControlE,
  output logic [DATA_WIDTH-1:0] RD1E,
  output logic [DATA_WIDTH-1:0] RD2E,
  output logic [DATA_WIDTH-1:0] SignImmE,
  output logic [4:0]            RsE,
  output logic [4:0]            RtE,
  output logic [4:0]            RdE
);

  logic [5:0]                   op_p0, funct_p0;
  logic [4:0]                   rs_p0, rt_p0, rd_p0;
  logic                         unused_shamt;
  idex_ctrl_t                   ctrl_p0;
  logic                         branch_p0, branch_ne_p0, jump_p0;
  logic signed [DATA_WIDTH-1:0] sign_imm_p0;
  logic signed [31:0]           br_off_p0;
  logic [DATA_WIDTH-1:0]        rd1_p0, rd2_p0, src_a_p0, src_b_p0;
  logic                         fwd_a_p0, fwd_b_p0, equal_p0, taken_p0;
  logic [4:0]                   write_reg_e;
  logic                         lw_stall, br_stall, stall;

  logic                         vld_p1;
  idex_ctrl_t                   idex_p1;
  logic [DATA_WIDTH-1:0]        rd1_p1, rd2_p1;
  logic signed [DATA_WIDTH-1:0] sign_imm_p1;

  // ---- stage p0: decode, register read, branch resolution ----
  assign op_p0        = InstrD[31:26];
  assign rs_p0        = InstrD[25:21];
  assign rt_p0        = InstrD[20:16];
  assign rd_p0        = InstrD[15:11];
  assign funct_p0     = InstrD[5:0];
  assign unused_shamt = ^InstrD[10:6];
  assign sign_imm_p0  = DATA_WIDTH'($signed(InstrD[15:0]));
  assign br_off_p0    = 32'($signed(InstrD[15:0]));

  always_comb begin
    ctrl_p0      = '0;
    ctrl_p0.rs   = rs_p0;
    ctrl_p0.rt   = rt_p0;
    ctrl_p0.rd   = rd_p0;
    branch_p0    = 1'b0;
    branch_ne_p0 = 1'b0;
    jump_p0      = 1'b0;
    case (op_p0)
      OP_RTYPE: begin
        ctrl_p0.reg_write = 1'b1;
        ctrl_p0.reg_dst   = 1'b1;
        case (funct_p0)
          FN_ADD:  ctrl_p0.alu_ctrl = ALU_ADD;
          FN_SUB:  ctrl_p0.alu_ctrl = ALU_SUB;
          FN_AND:  ctrl_p0.alu_ctrl = ALU_AND;
          FN_OR:   ctrl_p0.alu_ctrl = ALU_OR;
          FN_SLT:  ctrl_p0.alu_ctrl = ALU_SLT;
          default: begin
            ctrl_p0.reg_write = 1'b0;
            ctrl_p0.reg_dst   = 1'b0;
          end
        endcase
      end
      OP_LW: begin
        ctrl_p0.reg_write = 1'b1;
        ctrl_p0.memto_reg = 1'b1;
        ctrl_p0.alu_src   = 1'b1;
        ctrl_p0.alu_ctrl  = ALU_ADD;
      end
      OP_SW: begin
        ctrl_p0.mem_write = 1'b1;
        ctrl_p0.alu_src   = 1'b1;
        ctrl_p0.alu_ctrl  = ALU_ADD;
      end
      OP_ADDI: begin
        ctrl_p0.reg_write = 1'b1;
        ctrl_p0.alu_src   = 1'b1;
        ctrl_p0.alu_ctrl  = ALU_ADD;
      end
      OP_BEQ: begin
        branch_p0        = 1'b1;
        ctrl_p0.alu_ctrl = ALU_SUB;
      end
      OP_BNE: begin
        if (BNE_EN) begin
          branch_ne_p0     = 1'b1;
          ctrl_p0.alu_ctrl = ALU_SUB;
        end
      end
      OP_J:    jump_p0 = 1'b1;
      default: ;
    endcase
  end

  reg_file_bypass #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_rf (
    .CLK (CLK),
    .RST (RST),
    .we  (RegWriteW),
    .wa  (WriteRegW),
    .wd  (ResultW),
    .ra1 (rs_p0),
    .ra2 (rt_p0),
    .rd1 (rd1_p0),
    .rd2 (rd2_p0)
  );

  assign fwd_a_p0  = (rs_p0 != 5'd0) && RegWriteM && (WriteRegM == rs_p0);
  assign fwd_b_p0  = (rt_p0 != 5'd0) && RegWriteM && (WriteRegM == rt_p0);
  assign src_a_p0  = fwd_a_p0 ? ALUOutM : rd1_p0;
  assign src_b_p0  = fwd_b_p0 ? ALUOutM : rd2_p0;
  assign equal_p0  = (src_a_p0 == src_b_p0);
  assign taken_p0  = (branch_p0 && equal_p0) || (branch_ne_p0 && !equal_p0);
  assign PCBranchD = PCPlus4D + {br_off_p0[29:0], 2'b00};
  assign PCJumpD   = {PCPlus4D[31:28], InstrD[25:0], 2'b00};

  // Hazards look at what is in E (ID/EX register) and M (inputs).
  assign write_reg_e = idex_p1.reg_dst ? idex_p1.rd : idex_p1.rt;
  assign lw_stall = vld_p1 && idex_p1.memto_reg &&
                    ((idex_p1.rt == rs_p0) || (idex_p1.rt == rt_p0));
  assign br_stall = (branch_p0 || branch_ne_p0) &&
                    ((idex_p1.reg_write && (write_reg_e != 5'd0) &&
                      ((write_reg_e == rs_p0) || (write_reg_e == rt_p0))) ||
                     (MemtoRegM && (WriteRegM != 5'd0) &&
                      ((WriteRegM == rs_p0) || (WriteRegM == rt_p0))));
  assign stall  = ValidD && (lw_stall || br_stall);
  assign StallF = stall;
  assign StallD = stall;
  assign PCSrcD = stall ? 2'b00 : {jump_p0, taken_p0};
  assign FlushD = ValidD && !stall && (PCSrcD != 2'b00);

  // ---- stage p1: ID/EX register ----
  always_ff @(posedge CLK) begin
    if (RST || stall || !ValidD) begin
      vld_p1      <= 1'b0;
      idex_p1     <= '0;
      rd1_p1      <= '0;
      rd2_p1      <= '0;
      sign_imm_p1 <= '0;
    end else begin
      vld_p1      <= 1'b1;
      idex_p1     <= ctrl_p0;
      rd1_p1      <= rd1_p0;
      rd2_p1      <= rd2_p0;
      sign_imm_p1 <= sign_imm_p0;
    end
  end

  assign ValidE      = vld_p1;
  assign RegWriteE   = idex_p1.reg_write;
  assign MemtoRegE   = idex_p1.memto_reg;
  assign MemWriteE   = idex_p1.mem_write;
  assign ALUSrcE     = idex_p1.alu_src;
  assign RegDstE     = idex_p1.reg_dst;
  assign ALUControlE = idex_p1.alu_ctrl;
  assign RD1E        = rd1_p1;
  assign RD2E        = rd2_p1;
  assign SignImmE    = sign_imm_p1;
  assign RsE         = idex_p1.rs;
  assign RtE         = idex_p1.rt;
  assign RdE         = idex_p1.rd;

endmodule

// File: tb/tb_decode_stage_pipelined.sv
// Scoreboard bench for decode_stage_pipelined: two instances (32 regs with bne,
// 16 regs without bne) share stimulus and are checked against a behavioural model.
module tb_decode_stage_pipelined;

  typedef enum int {K_NOP, K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_LW, K_SW,
                    K_ADDI, K_BEQ, K_BNE, K_J} kind_e;

  typedef struct packed {
    logic v, rw, m2r, mw, asrc, rdst;
    logic [2:0] alu;
    logic [31:0] rd1, rd2, simm;
    logic [4:0] rs, rt, rd;
  } eobs_t;

  typedef struct packed {
    logic [1:0] pcsrc;
    logic [31:0] pcb, pcj;
    logic sf, sd, fl;
  } cobs_t;

  typedef struct packed {
    logic rst;
    logic [31:0] instr, pc4;
    logic vld, rww;
    logic [4:0] wrw;
    logic [31:0] resw;
    logic rwm, m2rm;
    logic [4:0] wrm;
    logic [31:0] alum;
  } stim_t;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RST = 1'b0, ValidD = 1'b0, RegWriteW = 1'b0, RegWriteM = 1'b0, MemtoRegM = 1'b0;
  logic [31:0] InstrD = '0, PCPlus4D = '0, ResultW = '0, ALUOutM = '0;
  logic [4:0] WriteRegW = '0, WriteRegM = '0;

  logic [1:0]  PCSrcD [2];
  logic [31:0] PCBranchD [2], PCJumpD [2], RD1E [2], RD2E [2], SignImmE [2];
  logic        StallF [2], StallD [2], FlushD [2], ValidE [2], RegWriteE [2];
  logic        MemtoRegE [2], MemWriteE [2], ALUSrcE [2], RegDstE [2];
  logic [2:0]  ALUControlE [2];
  logic [4:0]  RsE [2], RtE [2], RdE [2];

  eobs_t e_obs [2];
  cobs_t c_obs [2];

  decode_stage_pipelined #(.DATA_WIDTH(32), .NUM_REGS(32), .BNE_EN(1'b1)) u_dut0 (
    .CLK(CLK), .RST(RST), .InstrD(InstrD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .WriteRegM(WriteRegM), .ALUOutM(ALUOutM),
    .PCSrcD(PCSrcD[0]), .PCBranchD(PCBranchD[0]), .PCJumpD(PCJumpD[0]),
    .StallF(StallF[0]), .StallD(StallD[0]), .FlushD(FlushD[0]), .ValidE(ValidE[0]),
    .RegWriteE(RegWriteE[0]), .MemtoRegE(MemtoRegE[0]), .MemWriteE(MemWriteE[0]),
    .ALUSrcE(ALUSrcE[0]), .RegDstE(RegDstE[0]), .ALUControlE(ALUControlE[0]),
    .RD1E(RD1E[0]), .RD2E(RD2E[0]), .SignImmE(SignImmE[0]),
    .RsE(RsE[0]), .RtE(RtE[0]), .RdE(RdE[0]));

  decode_stage_pipelined #(.DATA_WIDTH(32), .NUM_REGS(16), .BNE_EN(1'b0)) u_dut1 (
    .CLK(CLK), .RST(RST), .InstrD(InstrD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .WriteRegM(WriteRegM), .ALUOutM(ALUOutM),
    .PCSrcD(PCSrcD[1]), .PCBranchD(PCBranchD[1]), .PCJumpD(PCJumpD[1]),
    .StallF(StallF[1]), .StallD(StallD[1]), .FlushD(FlushD[1]), .ValidE(ValidE[1]),
    .RegWriteE(RegWriteE[1]), .MemtoRegE(MemtoRegE[1]), .MemWriteE(MemWriteE[1]),
    .ALUSrcE(ALUSrcE[1]), .RegDstE(RegDstE[1]), .ALUControlE(ALUControlE[1]),
    .RD1E(RD1E[1]), .RD2E(RD2E[1]), .SignImmE(SignImmE[1]),
    .RsE(RsE[1]), .RtE(RtE[1]), .RdE(RdE[1]));

  for (genvar k = 0; k < 2; k++) begin : g_obs
    assign e_obs[k] = {ValidE[k], RegWriteE[k], MemtoRegE[k], MemWriteE[k], ALUSrcE[k],
                       RegDstE[k], ALUControlE[k], RD1E[k], RD2E[k], SignImmE[k],
                       RsE[k], RtE[k], RdE[k]};
    assign c_obs[k] = {PCSrcD[k], PCBranchD[k], PCJumpD[k], StallF[k], StallD[k], FlushD[k]};
  end

  int n_vec = 0;
  int n_bad = 0;
  stim_t nx;
  eobs_t q0[$], q1[$];
  logic [31:0] mregs [2][32];
  eobs_t mE [2];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rs, rt, rd);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic kind_e decode(input logic [31:0] ins, input bit bne_en);
    case (ins[31:26])
      6'h00: case (ins[5:0])
        6'h20: return K_ADD;
        6'h22: return K_SUB;
        6'h24: return K_AND;
        6'h25: return K_OR;
        6'h2A: return K_SLT;
        default: return K_NOP;
      endcase
      6'h23: return K_LW;
      6'h2B: return K_SW;
      6'h08: return K_ADDI;
      6'h04: return K_BEQ;
      6'h05: return bne_en ? K_BNE : K_NOP;
      6'h02: return K_J;
      default: return K_NOP;
    endcase
  endfunction

  function automatic logic [31:0] rdreg(input int k, input int nregs, input logic [4:0] a);
    if (a == 5'd0 || int'(a) >= nregs) return 32'd0;
    if (RegWriteW && a == WriteRegW) return ResultW;
    return mregs[k][a];
  endfunction

  task automatic model(input int k);
    int nregs;
    kind_e kd;
    logic [4:0] rs, rt, rd, we_e;
    logic [31:0] simm, a, b;
    bit lws, brs, stall, taken, isbr;
    eobs_t ne;
    cobs_t ce;
    nregs = (k == 0) ? 32 : 16;
    kd = decode(InstrD, k == 0);
    rs = InstrD[25:21];
    rt = InstrD[20:16];
    rd = InstrD[15:11];
    simm = {{16{InstrD[15]}}, InstrD[15:0]};
    we_e = mE[k].rdst ? mE[k].rd : mE[k].rt;
    lws = mE[k].v && mE[k].m2r && (mE[k].rt == rs || mE[k].rt == rt);
    isbr = (kd == K_BEQ) || (kd == K_BNE);
    brs = isbr && ((mE[k].rw && we_e != 5'd0 && (we_e == rs || we_e == rt)) ||
                   (MemtoRegM && WriteRegM != 5'd0 && (WriteRegM == rs || WriteRegM == rt)));
    stall = ValidD && (lws || brs);
    a = (rs != 5'd0 && RegWriteM && WriteRegM == rs) ? ALUOutM : rdreg(k, nregs, rs);
    b = (rt != 5'd0 && RegWriteM && WriteRegM == rt) ? ALUOutM : rdreg(k, nregs, rt);
    taken = (kd == K_BEQ && a == b) || (kd == K_BNE && a != b);
    ce.pcsrc = stall ? 2'b00 : {kd == K_J, taken};
    ce.pcb = PCPlus4D + simm * 4;
    ce.pcj = {PCPlus4D[31:28], InstrD[25:0], 2'b00};
    ce.sf = stall;
    ce.sd = stall;
    ce.fl = ValidD && !stall && ce.pcsrc != 2'b00;
    if (!RST) check($sformatf("comb_dut%0d", k), 128'(c_obs[k]), 128'(ce));
    ne = '0;
    if (!RST && !stall && ValidD) begin
      ne.v = 1'b1;
      ne.rw = kd inside {K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_LW, K_ADDI};
      ne.m2r = (kd == K_LW);
      ne.mw = (kd == K_SW);
      ne.asrc = kd inside {K_LW, K_SW, K_ADDI};
      ne.rdst = kd inside {K_ADD, K_SUB, K_AND, K_OR, K_SLT};
      case (kd)
        K_ADD, K_LW, K_SW, K_ADDI: ne.alu = 3'b010;
        K_SUB, K_BEQ, K_BNE:       ne.alu = 3'b110;
        K_OR:                      ne.alu = 3'b001;
        K_SLT:                     ne.alu = 3'b111;
        default:                   ne.alu = 3'b000;
      endcase
      ne.rd1 = rdreg(k, nregs, rs);
      ne.rd2 = rdreg(k, nregs, rt);
      ne.simm = simm;
      ne.rs = rs;
      ne.rt = rt;
      ne.rd = rd;
    end
    if (k == 0) q0.push_back(ne); else q1.push_back(ne);
    if (RST) begin
      for (int i = 0; i < 32; i++) mregs[k][i] = 32'd0;
    end else if (RegWriteW && WriteRegW != 5'd0 && int'(WriteRegW) < nregs) begin
      mregs[k][WriteRegW] = ResultW;
    end
    mE[k] = ne;
  endtask

  task automatic cyc();
    @(negedge CLK);
    RST = nx.rst; InstrD = nx.instr; PCPlus4D = nx.pc4; ValidD = nx.vld;
    RegWriteW = nx.rww; WriteRegW = nx.wrw; ResultW = nx.resw;
    RegWriteM = nx.rwm; MemtoRegM = nx.m2rm; WriteRegM = nx.wrm; ALUOutM = nx.alum;
    #2;
    model(0);
    model(1);
  endtask

  task automatic after_edge();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [4:0] rreg();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    int sel;
    logic [15:0] imm;
    sel = $urandom_range(0, 12);
    imm = 16'($urandom);
    case (sel)
      0, 1, 2, 3, 4: return rtype(fns[sel], rreg(), rreg(), rreg());
      5:  return itype(6'h23, rreg(), rreg(), imm);
      6:  return itype(6'h2B, rreg(), rreg(), imm);
      7:  return itype(6'h08, rreg(), rreg(), imm);
      8:  return itype(6'h04, rreg(), rreg(), imm);
      9:  return itype(6'h05, rreg(), rreg(), imm);
      10: return {6'h02, 26'($urandom)};
      11: return {6'($urandom), rreg(), rreg(), rreg(), 5'd0, 6'($urandom)};
      default: return $urandom;
    endcase
  endfunction

  initial begin : monitor
    eobs_t exp;
    forever begin
      @(posedge CLK);
      #1;
      if (q0.size() > 0) begin
        exp = q0.pop_front();
        check("E_dut0", 128'(e_obs[0]), 128'(exp));
      end
      if (q1.size() > 0) begin
        exp = q1.pop_front();
        check("E_dut1", 128'(e_obs[1]), 128'(exp));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "time limit");
  end

  initial begin : stimulus
    for (int k = 0; k < 2; k++) begin
      mE[k] = '0;
      for (int i = 0; i < 32; i++) mregs[k][i] = 32'd0;
    end
    nx = '0;
    nx.rst = 1'b1;
    cyc();
    cyc();
    nx.rst = 1'b0;

    // same-cycle write of r3 and read through bypass
    nx.vld = 1'b1; nx.rww = 1'b1; nx.wrw = 5'd3; nx.resw = 32'h55;
    nx.instr = rtype(6'h20, 5'd3, 5'd0, 5'd4);
    cyc();
    after_edge();
    check("bypass_rd1", 128'(RD1E[0]), 128'(32'h55));
    nx.wrw = 5'd0; nx.resw = 32'hdead;
    nx.instr = rtype(6'h20, 5'd0, 5'd3, 5'd4);
    cyc();
    after_edge();
    check("r0_write_ignored", 128'(RD1E[0]), 128'(32'h0));
    check("r3_held", 128'(RD2E[0]), 128'(32'h55));
    nx.instr = 32'h0; nx.wrw = 5'd1; nx.resw = 32'd5;
    cyc();
    nx.wrw = 5'd2;
    cyc();
    nx.rww = 1'b0;

    // load-use: one bubble
    nx.instr = itype(6'h23, 5'd1, 5'd2, 16'h0);
    cyc();
    nx.instr = rtype(6'h20, 5'd2, 5'd2, 5'd5);
    cyc();
    check("lu_stall", 128'(StallD[0]), 128'(1'b1));
    after_edge();
    check("lu_bubble_valid", 128'(ValidE[0]), 128'(1'b0));
    check("lu_bubble_ctrl", 128'({RegWriteE[0], MemtoRegE[0], ALUControlE[0]}), 128'(5'd0));
    cyc();
    check("lu_release", 128'(StallD[0]), 128'(1'b0));
    after_edge();
    check("lu_capture", 128'({ValidE[0], RegWriteE[0], RegDstE[0], RdE[0]}),
          128'({1'b1, 1'b1, 1'b1, 5'd5}));

    // branch after ALU producer: one stall, then forward from M
    nx.instr = rtype(6'h20, 5'd1, 5'd2, 5'd6);
    cyc();
    nx.instr = itype(6'h04, 5'd6, 5'd0, 16'd3); nx.pc4 = 32'h100;
    cyc();
    check("br_alu_stall", 128'(StallD[0]), 128'(1'b1));
    nx.rwm = 1'b1; nx.wrm = 5'd6; nx.alum = 32'd0;
    cyc();
    check("br_fwd_pcsrc", 128'(PCSrcD[0]), 128'(2'b01));
    check("br_fwd_flush", 128'(FlushD[0]), 128'(1'b1));
    check("br_target", 128'(PCBranchD[0]), 128'(32'h10C));
    nx.rwm = 1'b0; nx.wrm = 5'd0;

    // bne: equal operands, then r2=6 via bypass; dut1 has bne disabled
    nx.instr = itype(6'h05, 5'd1, 5'd2, 16'd5);
    cyc();
    check("bne_equal", 128'(PCSrcD[0]), 128'(2'b00));
    nx.rww = 1'b1; nx.wrw = 5'd2; nx.resw = 32'd6;
    cyc();
    check("bne_taken", 128'(PCSrcD[0]), 128'(2'b01));
    check("bne_disabled", 128'(PCSrcD[1]), 128'(2'b00));
    nx.rww = 1'b0;

    // jump
    nx.instr = {6'h02, 26'h0000010}; nx.pc4 = 32'h30000004;
    cyc();
    check("j_pcsrc", 128'(PCSrcD[0]), 128'(2'b10));
    check("j_target", 128'(PCJumpD[0]), 128'(32'h30000040));
    check("j_flush", 128'(FlushD[0]), 128'(1'b1));

    // r20 exists only in the 32-register instance
    nx.rww = 1'b1; nx.wrw = 5'd20; nx.resw = 32'h77;
    nx.instr = rtype(6'h20, 5'd20, 5'd0, 5'd1);
    cyc();
    after_edge();
    check("nr16_bypass_oob", 128'(RD1E[1]), 128'(32'h0));
    check("nr32_bypass", 128'(RD1E[0]), 128'(32'h77));
    nx.rww = 1'b0;
    cyc();
    after_edge();
    check("nr16_read_oob", 128'(RD1E[1]), 128'(32'h0));
    check("nr32_read", 128'(RD1E[0]), 128'(32'h77));

    // reset while a load-use stall is active
    nx.instr = itype(6'h23, 5'd0, 5'd7, 16'd4);
    cyc();
    nx.instr = rtype(6'h20, 5'd7, 5'd0, 5'd8); nx.rst = 1'b1;
    cyc();
    check("rst_stall_seen", 128'(StallD[0]), 128'(1'b1));
    after_edge();
    check("rst_e_clear0", 128'(e_obs[0]), 128'(0));
    check("rst_e_clear1", 128'(e_obs[1]), 128'(0));
    nx.rst = 1'b0;

    for (int i = 0; i < 400; i++) begin
      nx.rst   = ($urandom_range(0, 99) == 0);
      nx.vld   = ($urandom_range(0, 9) != 0);
      nx.instr = rand_instr();
      nx.pc4   = $urandom & 32'hFFFF_FFFC;
      nx.rww   = 1'($urandom_range(0, 1));
      nx.wrw   = rreg();
      nx.resw  = 32'($urandom_range(0, 3));
      nx.rwm   = 1'($urandom_range(0, 1));
      nx.m2rm  = ($urandom_range(0, 3) == 0);
      nx.wrm   = rreg();
      nx.alum  = 32'($urandom_range(0, 3));
      cyc();
    end

    nx = '0;
    cyc();
    after_edge();
    #2;
    check("queue_drain", 128'(q0.size() + q1.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
